// File: rtl/stolen_cdc_pkg.sv
// Shared definitions for the stolen_cdc four-phase handshake transmitter and
// its matching receiver: FSM state encoding and synchronizer depth limits.
package stolen_cdc_pkg;

    // Handshake FSM states, 2-bit encoding shared with the receiver side.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ACK_WAIT = 2'd2
    } cdc_state_t;

    // Legal synchronizer depth range for the returning acknowledge.
    localparam int DEST_SYNC_FF_MIN = 2;
    localparam int DEST_SYNC_FF_MAX = 10;

    // Pulls an out-of-range depth back into the legal window so that a bad
    // parameter never produces a zero- or one-stage (unsafe) synchronizer.
    function automatic int clamp_sync_ff(input int n);
        if (n < DEST_SYNC_FF_MIN) return DEST_SYNC_FF_MIN;
        if (n > DEST_SYNC_FF_MAX) return DEST_SYNC_FF_MAX;
        return n;
    endfunction

endpackage

// File: rtl/stolen_cdc_handshake_tx_if.sv
// Bundle of the valid/ready source port and the req/ack/data crossing port
// of the handshake transmitter. The slave modport is the transmitter's view.
interface stolen_cdc_handshake_tx_if #(
    parameter int WIDTH = 8
);

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_ready;
    logic             src_done;
    logic             xfer_req;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_ack_async;

    // Environment side: supplies words and returns the acknowledge.
    modport master (
        output src_valid,
        output src_data,
        output xfer_ack_async,
        input  src_ready,
        input  src_done,
        input  xfer_req,
        input  xfer_data
    );

    // Transmitter side.
    modport slave (
        input  src_valid,
        input  src_data,
        input  xfer_ack_async,
        output src_ready,
        output src_done,
        output xfer_req,
        output xfer_data
    );

endinterface

// File: rtl/stolen_cdc_sync_arst.sv
// Single-bit multi-stage synchronizer with asynchronous active-high reset
// to 0. Kept as its own hierarchy so CDC constraints can find the stages.
(* keep_hierarchy = "yes" *)
module stolen_cdc_sync_arst #(
    parameter int STAGES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE", STOLEN_CDC = "ack_sync" *)
    logic [STAGES-1:0] sync_ff;

    // Shift the asynchronous input through the chain; reset clears every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[STAGES-2:0], d};
        end
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/stolen_cdc_handshake_tx.sv
// Source-side transmitter of a four-phase req/ack CDC handshake. A word
// accepted under valid/ready is held on xfer_data while xfer_req walks the
// req-high / ack-high / req-low / ack-low cycle against the synchronized ack.
module stolen_cdc_handshake_tx
    import stolen_cdc_pkg::*;
#(
    parameter int DEST_SYNC_FF = 4,
    parameter int WIDTH        = 8
) (
    input  logic                        src_clk,
    input  logic                        src_rst,
    stolen_cdc_handshake_tx_if.slave    bus
);

    localparam int SYNC_FF = clamp_sync_ff(DEST_SYNC_FF);

    cdc_state_t       state;
    cdc_state_t       state_next;
    logic             ack_sync;
    logic             ready;
    logic             accept;
    logic             req_next;
    logic             done_next;
    logic             done_r;

    (* STOLEN_CDC = "xfer_req" *)
    logic             xfer_req_r;
    (* STOLEN_CDC = "xfer_data" *)
    logic [WIDTH-1:0] xfer_data_r;

    // The synchronized ack is the only place the destination's ack is used,
    // so there is no combinational path from xfer_ack_async to any output.
    stolen_cdc_sync_arst #(
        .STAGES (SYNC_FF)
    ) u_ack_sync (
        .clk (src_clk),
        .rst (src_rst),
        .d   (bus.xfer_ack_async),
        .q   (ack_sync)
    );

    // A stale high ack seen while idle blocks new transfers until it clears.
    assign ready  = (state == IDLE) & ~ack_sync;
    assign accept = bus.src_valid & ready;

    // Next-state and registered-output decode for the four-phase cycle.
    always_comb begin
        state_next = state;
        req_next   = 1'b0;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                end
            end
            REQ: begin
                req_next = 1'b1;
                if (ack_sync) begin
                    state_next = ACK_WAIT;
                    req_next   = 1'b0;
                end
            end
            ACK_WAIT: begin
                if (!ack_sync) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, request and completion pulse registers.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state      <= IDLE;
            xfer_req_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state      <= state_next;
            xfer_req_r <= req_next;
            done_r     <= done_next;
        end
    end

    // Held word: loads only on accept, so it is frozen through REQ and ACK_WAIT.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            xfer_data_r <= '0;
        end else if (accept) begin
            xfer_data_r <= bus.src_data;
        end
    end

    assign bus.src_ready = ready;
    assign bus.src_done  = done_r;
    assign bus.xfer_req  = xfer_req_r;
    assign bus.xfer_data = xfer_data_r;

endmodule

// File: doc/stolen_cdc_handshake_tx.md
# stolen_cdc_handshake_tx

Source-side transmitter of a four-phase req/ack clock-domain-crossing handshake. It accepts a WIDTH-bit word under valid/ready in the `src_clk` domain and holds that word stable on `xfer_data` while driving a registered `xfer_req` toward the destination domain. It synchronizes the returning `xfer_ack_async` through a DEST_SYNC_FF-stage chain and completes the req-high/ack-high/req-low/ack-low cycle before accepting the next word. It is the initiator counterpart to a destination-side handshake receiver, and is used wherever multi-bit non-gray data crosses domains.

## Interface
- DEST_SYNC_FF, 4: synchronizer stages on `xfer_ack_async`; legal range 2..10.
- WIDTH, 8: data word width; legal range 1..1024.
- src_clk  in  1  sole clock; all state updates on its rising edge.
- src_rst  in  1  reset, asynchronous, active-high; also clears the ack synchronizer stages.
- src_valid  in  1  source word available.
- src_data  in  WIDTH  source word; sampled only on accept.
- src_ready  out  1  block can accept; combinational = (state==IDLE) & ~ack_sync.
- src_done  out  1  one-cycle registered pulse when a transfer's four-phase cycle completes.
- xfer_req  out  1  registered request to the destination domain.
- xfer_data  out  WIDTH  registered held word; stable whenever `xfer_req`=1 or the FSM is in ACK_WAIT.
- xfer_ack_async  in  1  acknowledge from the destination domain; asynchronous to `src_clk`.

## Operation
- ack_sync = last stage of the DEST_SYNC_FF chain fed by `xfer_ack_async`. It is the only use of the ack.
- Accept = `src_valid` & `src_ready` at a rising edge. On accept: `xfer_data`<=`src_data`, `xfer_req`<=1, state IDLE->REQ.
- FSM states:
  - IDLE: accept -> REQ; otherwise hold.
  - REQ: `xfer_req`=1. When ack_sync=1 -> ACK_WAIT and `xfer_req`<=0.
  - ACK_WAIT: `xfer_req`=0. When ack_sync=0 -> IDLE and `src_done`<=1 for one cycle.
- `xfer_data` changes only on accept. It is never modified in REQ or ACK_WAIT.
- Stale ack: if ack_sync=1 while IDLE (for example after an asymmetric reset), `src_ready` stays 0 until ack_sync returns to 0. No transfer starts against a high ack.
- An ack that pulses high and drops before reaching ack_sync leaves REQ unaffected; the FSM waits for a synchronized high level.
- `src_valid` without ready: no state change. `src_data` is ignored.
- Reset values (immediate on `src_rst`, asynchronous):
  - state=IDLE
  - `xfer_req`=0, `xfer_data`=0, `src_done`=0
  - all sync stages=0, so `src_ready`=1 once reset deasserts
- Reset mid-transfer: `xfer_req` drops at once and the word is lost with no `src_done`. The destination side must be reset in the same event; this is a system-level requirement.

## Timing
- Let K=DEST_SYNC_FF and let accept occur at edge N.
- `xfer_req`/`xfer_data` are valid after edge N.
- With a zero-delay external loop (ack = req):
  - ack_sync=1 after edge N+K.
  - `xfer_req` falls after edge N+K+1.
  - ack_sync=0 after edge N+2K+1.
  - IDLE and `src_done`=1 after edge N+2K+2.
  - Next earliest accept is at edge N+2K+3, giving a minimum period of 2K+3 cycles (11 for K=4).
- `src_done` is high for exactly one cycle per completed transfer. It is never asserted without a prior accept.
- No combinational path from `xfer_ack_async` to any output. `src_ready` depends only on registered state and ack_sync.

## Structure
- Shared package `stolen_cdc_pkg`: state typedef (IDLE, REQ, ACK_WAIT; 2-bit encoding) and DEST_SYNC_FF range constants. The package is reused by the matching receiver.
- Sub-module `stolen_cdc_sync_arst`: single-bit DEST_SYNC_FF-stage synchronizer with async active-high reset to 0.
  - Stages carry ASYNC_REG/DONT_TOUCH attributes and a STOLEN_CDC tag, keeping hierarchy.
  - Instantiated once, for the ack.
- `xfer_data` and `xfer_req` registers carry a STOLEN_CDC tag for constraint scripts.

## Test plan
- Loopback ack=req, K=4: send 0xA5 -> `xfer_data`=0xA5 after accept edge; `xfer_req` high 5 cycles; `src_done` pulse 10 cycles after accept; second word accepted 11 cycles after first.
- Back-to-back `src_valid` with words 0x01..0x10 and a random 1–20 cycle external ack delay -> 16 `src_done` pulses; captured data in order; `xfer_data` never changes while req or ACK_WAIT.
- Hold ack=1 through reset release -> `src_ready`=0 until ack low plus K cycles; no `xfer_req` meanwhile.
- Assert `src_rst` during REQ -> `xfer_req`=0, `xfer_data`=0 same cycle; no `src_done`; after release `src_ready`=1 once ack low.
- 1-cycle ack glitch (shorter than sample, asynchronous phase) during REQ -> FSM remains REQ or advances only on a synchronized level; never skips to IDLE without ACK_WAIT.
- `src_valid` with changing `src_data` while not ready -> no accept; latched word equals `src_data` at the accept edge only.
